// File: rtl/mm_bus_arbiter_if.sv
// Bundles the requester-side and slave-side signals of the shared memory-mapped bus.
// The arbiter connects through the slave modport; requesters and slaves drive the master side.
interface mm_bus_arbiter_if #(
  parameter int MM_ADDR_WIDTH = 8,
  parameter int MM_DATA_WIDTH = 16,
  parameter int NUM_MASTERS   = 3,
  parameter int ID_WIDTH      = 3
);
  logic [NUM_MASTERS-1:0]               m_req_i;
  logic [NUM_MASTERS*MM_ADDR_WIDTH-1:0] m_addr_i;
  logic [NUM_MASTERS*MM_DATA_WIDTH-1:0] m_wdata_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [MM_DATA_WIDTH-1:0]             m_rdata_o;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [MM_ADDR_WIDTH-1:0]             mm_m_addr_o;
  logic [MM_DATA_WIDTH-1:0]             mm_m_wdata_o;
  logic                                 mm_m_we_o;
  logic [MM_DATA_WIDTH-1:0]             mm_m_rdata_i;
  logic [ID_WIDTH-1:0]                  grant_id_o;
  logic                                 busy_o;

  modport slave (
    input  m_req_i, m_addr_i, m_wdata_i, m_we_i, mm_m_rdata_i,
    output m_rdata_o, m_ack_o, mm_m_addr_o, mm_m_wdata_o, mm_m_we_o, grant_id_o, busy_o
  );

  modport master (
    output m_req_i, m_addr_i, m_wdata_i, m_we_i, mm_m_rdata_i,
    input  m_rdata_o, m_ack_o, mm_m_addr_o, mm_m_wdata_o, mm_m_we_o, grant_id_o, busy_o
  );
endinterface

// File: rtl/mm_bus_arbiter.sv
// Round-robin arbiter sharing one memory-mapped slave bus among NUM_MASTERS requesters.
// Each grant occupies exactly three cycles (IDLE sample, ACCESS, DONE); all outputs are registered.
module mm_bus_arbiter #(
  parameter int MM_ADDR_WIDTH = 8,
  parameter int MM_DATA_WIDTH = 16,
  parameter int NUM_MASTERS   = 3,
  parameter int ID_WIDTH      = 3
) (
  input logic              clk_sys_i,
  input logic              rst_i,
  mm_bus_arbiter_if.slave  bus
);
  localparam int AW = MM_ADDR_WIDTH;
  localparam int DW = MM_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    ACCESS = 3'b010,
    DONE   = 3'b100
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [DW-1:0]           rdata_q, rdata_d;
  logic                    busy_q, busy_d;

  logic                    found;
  logic [ID_WIDTH-1:0]     sel;
  int                      idx;

  // Rotating priority: first requester after the last winner.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!found && (k == idx) && bus.m_req_i[k]) begin
          found = 1'b1;
          sel   = ID_WIDTH'(k);
        end
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    rdata_d    = rdata_q;
    addr_d     = '0;
    wdata_d    = '0;
    we_d       = 1'b0;
    ack_d      = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = ACCESS;
          grant_id_d = sel;
          rr_ptr_d   = sel;
          for (int k = 0; k < NUM_MASTERS; k++) begin
            if (sel == ID_WIDTH'(k)) begin
              addr_d  = bus.m_addr_i[k*AW +: AW];
              wdata_d = bus.m_wdata_i[k*DW +: DW];
              we_d    = bus.m_we_i[k];
            end
          end
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!we_q) rdata_d = bus.mm_m_rdata_i;
        for (int k = 0; k < NUM_MASTERS; k++) ack_d[k] = (grant_id_q == ID_WIDTH'(k));
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= ID_WIDTH'(NUM_MASTERS - 1);
      grant_id_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mm_m_addr_o  = addr_q;
  assign bus.mm_m_wdata_o = wdata_q;
  assign bus.mm_m_we_o    = we_q;
  assign bus.m_ack_o      = ack_q;
  assign bus.m_rdata_o    = rdata_q;
  assign bus.grant_id_o   = grant_id_q;
  assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Directed bench for mm_bus_arbiter: reset, single write/read, rotation, repeat grants,
// asynchronous abort and a request withdrawn before it is sampled.
module tb_mm_bus_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NM = 3;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mm_bus_arbiter_if #(.MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW), .NUM_MASTERS(NM), .ID_WIDTH(IW)) bus ();

  mm_bus_arbiter #(.MM_ADDR_WIDTH(AW), .MM_DATA_WIDTH(DW), .NUM_MASTERS(NM), .ID_WIDTH(IW)) dut (
    .clk_sys_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Slave model: one register at 0x14 returns 0x8ABC, everything else 0x1234.
  assign bus.mm_m_rdata_i = (bus.mm_m_addr_o == 8'h14) ? 16'h8ABC : 16'h1234;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    bus.m_addr_i[k*AW +: AW]  = a;
    bus.m_wdata_i[k*DW +: DW] = d;
    bus.m_we_i[k]             = w;
  endtask

  task automatic do_reset();
    bus.m_req_i = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.m_req_i   = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.m_we_i    = '0;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (bus.mm_m_we_o !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", bus.mm_m_we_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    n_checks++; if (bus.m_ack_o !== 3'b000) begin n_errors++; $display("FAIL reset_ack: got %b want 000", bus.m_ack_o); end
    n_checks++; if (bus.grant_id_o !== 3'd0) begin n_errors++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id_o); end
    n_checks++; if (bus.mm_m_addr_o !== 8'h00 || bus.mm_m_wdata_o !== 16'h0000 || bus.m_rdata_o !== 16'h0000) begin
      n_errors++; $display("FAIL reset_bus: addr %h wdata %h rdata %h want all 0", bus.mm_m_addr_o, bus.mm_m_wdata_o, bus.m_rdata_o);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_write();
    do_reset();
    set_master(0, 8'h10, 16'h0001, 1'b1);
    bus.m_req_i = 3'b001;
    tick();
    n_checks++; if (bus.mm_m_we_o !== 1'b1) begin n_errors++; $display("FAIL wr_we_access: got %b want 1", bus.mm_m_we_o); end
    n_checks++; if (bus.mm_m_addr_o !== 8'h10) begin n_errors++; $display("FAIL wr_addr: got %h want 10", bus.mm_m_addr_o); end
    n_checks++; if (bus.mm_m_wdata_o !== 16'h0001) begin n_errors++; $display("FAIL wr_wdata: got %h want 0001", bus.mm_m_wdata_o); end
    n_checks++; if (bus.grant_id_o !== 3'd0) begin n_errors++; $display("FAIL wr_grant: got %0d want 0", bus.grant_id_o); end
    n_checks++; if (bus.busy_o !== 1'b1 || bus.m_ack_o !== 3'b000) begin
      n_errors++; $display("FAIL wr_access_state: busy %b ack %b want 1 000", bus.busy_o, bus.m_ack_o);
    end
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b001) begin n_errors++; $display("FAIL wr_ack: got %b want 001", bus.m_ack_o); end
    n_checks++; if (bus.mm_m_we_o !== 1'b0 || bus.mm_m_addr_o !== 8'h00) begin
      n_errors++; $display("FAIL wr_done_bus: we %b addr %h want 0 00", bus.mm_m_we_o, bus.mm_m_addr_o);
    end
    n_checks++; if (bus.busy_o !== 1'b1) begin n_errors++; $display("FAIL wr_done_busy: got %b want 1", bus.busy_o); end
    bus.m_req_i = 3'b000;
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b000 || bus.busy_o !== 1'b0) begin
      n_errors++; $display("FAIL wr_idle: ack %b busy %b want 000 0", bus.m_ack_o, bus.busy_o);
    end
    tick();
    n_checks++; if (bus.mm_m_we_o !== 1'b0) begin n_errors++; $display("FAIL wr_no_repeat: we %b want 0", bus.mm_m_we_o); end
  endtask

  task automatic test_read();
    set_master(1, 8'h14, 16'hFFFF, 1'b0);
    bus.m_req_i = 3'b010;
    tick();
    n_checks++; if (bus.mm_m_addr_o !== 8'h14 || bus.mm_m_we_o !== 1'b0) begin
      n_errors++; $display("FAIL rd_access: addr %h we %b want 14 0", bus.mm_m_addr_o, bus.mm_m_we_o);
    end
    n_checks++; if (bus.grant_id_o !== 3'd1) begin n_errors++; $display("FAIL rd_grant: got %0d want 1", bus.grant_id_o); end
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b010) begin n_errors++; $display("FAIL rd_ack: got %b want 010", bus.m_ack_o); end
    n_checks++; if (bus.m_rdata_o !== 16'h8ABC) begin n_errors++; $display("FAIL rd_data: got %h want 8abc", bus.m_rdata_o); end
    n_checks++; if (bus.mm_m_we_o !== 1'b0) begin n_errors++; $display("FAIL rd_we_done: got %b want 0", bus.mm_m_we_o); end
    bus.m_req_i = 3'b000;
    tick();
  endtask

  task automatic test_rotation();
    logic [2:0] we_map;
    int exp;
    we_map = 3'b101;
    do_reset();
    for (int k = 0; k < NM; k++) set_master(k, 8'(8'h20 + k), 16'(16'h0100 + k), we_map[k]);
    bus.m_req_i = 3'b111;
    for (int t = 0; t < 6; t++) begin
      exp = t % 3;
      tick();
      n_checks++; if (bus.grant_id_o !== 3'(exp)) begin n_errors++; $display("FAIL rot_grant[%0d]: got %0d want %0d", t, bus.grant_id_o, exp); end
      n_checks++; if (bus.mm_m_addr_o !== 8'(8'h20 + exp) || bus.mm_m_we_o !== we_map[exp]) begin
        n_errors++; $display("FAIL rot_bus[%0d]: addr %h we %b want %h %b", t, bus.mm_m_addr_o, bus.mm_m_we_o, 8'(8'h20 + exp), we_map[exp]);
      end
      tick();
      n_checks++; if (bus.m_ack_o !== 3'(1 << exp)) begin n_errors++; $display("FAIL rot_ack[%0d]: got %b want %b", t, bus.m_ack_o, 3'(1 << exp)); end
      n_checks++; if (bus.m_rdata_o !== 16'h1234 && exp == 1) begin n_errors++; $display("FAIL rot_rdata[%0d]: got %h want 1234", t, bus.m_rdata_o); end
      tick();
      n_checks++; if (bus.m_ack_o !== 3'b000 || bus.busy_o !== 1'b0) begin
        n_errors++; $display("FAIL rot_idle[%0d]: ack %b busy %b want 000 0", t, bus.m_ack_o, bus.busy_o);
      end
    end
    bus.m_req_i = 3'b000;
    tick();
  endtask

  task automatic test_back_to_back();
    int we_cnt, ack_cnt;
    logic prev_we;
    we_cnt = 0; ack_cnt = 0; prev_we = 1'b0;
    do_reset();
    set_master(2, 8'h30, 16'hBEEF, 1'b1);
    bus.m_req_i = 3'b100;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++; if (bus.mm_m_we_o !== (i % 3 == 0)) begin n_errors++; $display("FAIL b2b_we[%0d]: got %b want %b", i, bus.mm_m_we_o, (i % 3 == 0)); end
      n_checks++; if (prev_we && bus.mm_m_we_o) begin n_errors++; $display("FAIL b2b_we_consec[%0d]: got 1 want 0", i); end
      n_checks++; if (bus.grant_id_o !== 3'd2) begin n_errors++; $display("FAIL b2b_grant[%0d]: got %0d want 2", i, bus.grant_id_o); end
      if (bus.mm_m_we_o === 1'b1) we_cnt++;
      if (bus.m_ack_o === 3'b100) ack_cnt++;
      prev_we = bus.mm_m_we_o;
    end
    n_checks++; if (we_cnt != 3) begin n_errors++; $display("FAIL b2b_we_count: got %0d want 3", we_cnt); end
    n_checks++; if (ack_cnt != 3) begin n_errors++; $display("FAIL b2b_ack_count: got %0d want 3", ack_cnt); end
    bus.m_req_i = 3'b000;
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    do_reset();
    set_master(0, 8'h40, 16'hAAAA, 1'b1);
    set_master(1, 8'h41, 16'h5555, 1'b0);
    bus.m_req_i = 3'b001;
    tick();
    n_checks++; if (bus.mm_m_we_o !== 1'b1) begin n_errors++; $display("FAIL abort_pre_we: got %b want 1", bus.mm_m_we_o); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.mm_m_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_errors++; $display("FAIL abort_async: we %b busy %b want 0 0", bus.mm_m_we_o, bus.busy_o);
    end
    n_checks++; if (bus.mm_m_addr_o !== 8'h00 || bus.m_ack_o !== 3'b000) begin
      n_errors++; $display("FAIL abort_bus: addr %h ack %b want 00 000", bus.mm_m_addr_o, bus.m_ack_o);
    end
    bus.m_req_i = 3'b000;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b000) begin n_errors++; $display("FAIL abort_no_ack: got %b want 000", bus.m_ack_o); end
    bus.m_req_i = 3'b011;
    tick();
    n_checks++; if (bus.grant_id_o !== 3'd0 || bus.mm_m_addr_o !== 8'h40) begin
      n_errors++; $display("FAIL abort_prio: grant %0d addr %h want 0 40", bus.grant_id_o, bus.mm_m_addr_o);
    end
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b001) begin n_errors++; $display("FAIL abort_reack0: got %b want 001", bus.m_ack_o); end
    bus.m_req_i = 3'b010;
    tick();
    tick();
    n_checks++; if (bus.grant_id_o !== 3'd1) begin n_errors++; $display("FAIL abort_next: got %0d want 1", bus.grant_id_o); end
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b010 || bus.m_rdata_o !== 16'h1234) begin
      n_errors++; $display("FAIL abort_ack1: ack %b rdata %h want 010 1234", bus.m_ack_o, bus.m_rdata_o);
    end
    bus.m_req_i = 3'b000;
    tick();
  endtask

  task automatic test_drop_req();
    do_reset();
    set_master(0, 8'h50, 16'h1111, 1'b1);
    set_master(1, 8'h51, 16'h2222, 1'b1);
    bus.m_req_i = 3'b001;
    tick();
    bus.m_req_i = 3'b011;
    tick();
    n_checks++; if (bus.m_ack_o !== 3'b001) begin n_errors++; $display("FAIL drop_ack0: got %b want 001", bus.m_ack_o); end
    bus.m_req_i = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.m_ack_o[1] !== 1'b0 || bus.busy_o !== 1'b0) begin
        n_errors++; $display("FAIL drop_never[%0d]: ack %b busy %b want 0x0 0", i, bus.m_ack_o, bus.busy_o);
      end
    end
    n_checks++; if (bus.mm_m_addr_o !== 8'h00 || bus.mm_m_wdata_o !== 16'h0000 || bus.mm_m_we_o !== 1'b0 || bus.m_ack_o !== 3'b000) begin
      n_errors++; $display("FAIL drop_final: addr %h wdata %h we %b ack %b want all 0", bus.mm_m_addr_o, bus.mm_m_wdata_o, bus.mm_m_we_o, bus.m_ack_o);
    end
    n_checks++; if (bus.grant_id_o !== 3'd0) begin n_errors++; $display("FAIL drop_grant: got %0d want 0", bus.grant_id_o); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_rotation();
    test_back_to_back();
    test_reset_abort();
    test_drop_req();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
